mac16_accumulator: RTL and testbench

16×16 multiply-accumulate block with a 40-bit accumulator, used inside the eFPGA math unit. Each enabled clock, it multiplies two 16-bit operands, signed or unsigned, and adds the product to a feedback value. The feedback value is the accumulator, zero, or a rounding constant. It then presents a selectable 16-bit window of the accumulator, with optional saturation.

---
 rtl/mac16_accumulator_pkg.sv | 20 ++
 rtl/mac16_accumulator_if.sv | 27 ++
 rtl/mac16_accumulator_mac_mul_add.sv | 39 +++
 rtl/mac16_accumulator.sv | 90 +++++++++
 tb/tb_mac16_accumulator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac16_accumulator_pkg.sv
// Shared widths and helpers for the 16x16 MAC with 40-bit accumulator.
package mac16_accumulator_pkg;

  localparam int OPER_W      = 16;
  localparam int EXT_W       = 20;
  localparam int ACC_W       = 40;
  localparam int OUT_SEL_MAX = 24;
  localparam int SEL_W       = 6;

  // Half-LSB of the selected output window; zero when no window shift applies.
  function automatic logic [ACC_W-1:0] rnd_const(input logic [SEL_W-1:0] sel);
    logic [ACC_W-1:0] r;
    r = '0;
    if (sel >= SEL_W'(1) && sel <= SEL_W'(OUT_SEL_MAX)) begin
      r = ACC_W'(1) << (sel - SEL_W'(1));
    end
    return r;
  endfunction

endpackage

// File: rtl/mac16_accumulator_if.sv
// Operand, control and result bundle of the MAC accumulator.
interface mac16_accumulator_if;
  import mac16_accumulator_pkg::*;

  logic                 EFPGA_MATHB_CLK_EN;
  logic [OPER_W-1:0]    MAC_OPER_DATA;
  logic [OPER_W-1:0]    MAC_COEF_DATA;
  logic                 MAC_ACC_RND;
  logic                 MAC_ACC_CLEAR;
  logic                 MAC_ACC_SAT;
  logic [SEL_W-1:0]     MAC_OUT_SEL;
  logic                 MAC_TC;
  logic [OPER_W-1:0]    MAC_OUT;

  modport master (
    output EFPGA_MATHB_CLK_EN, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_RND,
           MAC_ACC_CLEAR, MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC,
    input  MAC_OUT
  );

  modport slave (
    input  EFPGA_MATHB_CLK_EN, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_RND,
           MAC_ACC_CLEAR, MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC,
    output MAC_OUT
  );

endinterface

// File: rtl/mac16_accumulator_mac_mul_add.sv
// Combinational MAC = A*B + C (mod 2^40) on 20-bit extended operands.
module mac_mul_add
  import mac16_accumulator_pkg::*;
#(
  parameter int USE_BW = 0
) (
  input  logic [EXT_W-1:0] A,
  input  logic [EXT_W-1:0] B,
  input  logic [ACC_W-1:0] C,
  input  logic             TC,
  output logic [ACC_W-1:0] MAC
);

  logic [ACC_W-1:0] a_wide;
  assign a_wide = {{(ACC_W-EXT_W){TC & A[EXT_W-1]}}, A};

  generate
    if (USE_BW != 0) begin : g_bw
      logic [ACC_W-1:0] b_wide;
      assign b_wide = {{(ACC_W-EXT_W){TC & B[EXT_W-1]}}, B};
      assign MAC    = a_wide * b_wide + C;
    end else begin : g_lib
      logic [EXT_W:0][ACC_W-1:0] chain;
      assign chain[0] = C;
      for (genvar gi = 0; gi < EXT_W; gi++) begin : g_pp
        logic [ACC_W-1:0] pp;
        assign pp = B[gi] ? (a_wide << gi) : '0;
        if (gi == EXT_W - 1) begin : g_msb
          // The top bit of a two's-complement multiplier has negative weight.
          assign chain[gi+1] = TC ? (chain[gi] - pp) : (chain[gi] + pp);
        end else begin : g_mid
          assign chain[gi+1] = chain[gi] + pp;
        end
      end
      assign MAC = chain[EXT_W];
    end
  endgenerate

endmodule

// File: rtl/mac16_accumulator.sv
// 16x16 signed/unsigned multiply-accumulate with rounding, window select and saturation.
module mac16_accumulator
  import mac16_accumulator_pkg::*;
#(
  parameter int USE_BW      = 0,
  parameter int MULTI_WIDTH = 16
) (
  input  logic               MAC_ACC_CLK,
  input  logic               acc_ff_rstn,
  mac16_accumulator_if.slave bus
);

  logic [MULTI_WIDTH-1:0] oper_a;
  logic [MULTI_WIDTH-1:0] oper_b;
  logic [EXT_W-1:0]       a_ext;
  logic [EXT_W-1:0]       b_ext;
  logic [ACC_W-1:0]       feedback;
  logic [ACC_W-1:0]       mac_sum;
  logic [ACC_W-1:0]       acc_reg;
  logic [ACC_W-1:0]       acc_next;
  logic [SEL_W-1:0]       fsel_reg;

  assign oper_a = bus.MAC_OPER_DATA;
  assign oper_b = bus.MAC_COEF_DATA;
  assign a_ext  = {{(EXT_W-MULTI_WIDTH){bus.MAC_TC & oper_a[MULTI_WIDTH-1]}}, oper_a};
  assign b_ext  = {{(EXT_W-MULTI_WIDTH){bus.MAC_TC & oper_b[MULTI_WIDTH-1]}}, oper_b};

  // Rounding follows the live select so it lands on the edge fsel picks it up.
  always_comb begin
    feedback = acc_reg;
    if (bus.MAC_ACC_CLEAR) begin
      feedback = '0;
    end else if (bus.MAC_ACC_RND) begin
      feedback = rnd_const(bus.MAC_OUT_SEL);
    end
  end

  mac_mul_add #(
    .USE_BW (USE_BW)
  ) u_mul_add (
    .A   (a_ext),
    .B   (b_ext),
    .C   (feedback),
    .TC  (bus.MAC_TC),
    .MAC (mac_sum)
  );

  assign acc_next = bus.EFPGA_MATHB_CLK_EN ? mac_sum : acc_reg;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      acc_reg  <= '0;
      fsel_reg <= '0;
    end else begin
      acc_reg  <= acc_next;
      fsel_reg <= bus.MAC_OUT_SEL;
    end
  end

  logic [SEL_W-1:0]        win_sel;
  logic [SEL_W-1:0]        sat_sel;
  logic [ACC_W-1:0]        win_shift;
  logic signed [ACC_W-1:0] hi_signed;
  logic [ACC_W-1:0]        hi_unsigned;
  logic [OPER_W-1:0]       window;
  logic                    no_sat;

  always_comb begin
    win_sel     = (fsel_reg > SEL_W'(OUT_SEL_MAX)) ? '0 : fsel_reg;
    sat_sel     = (fsel_reg < SEL_W'(OUT_SEL_MAX)) ? fsel_reg : '0;
    win_shift   = acc_reg >> win_sel;
    window      = win_shift[OPER_W-1:0];
    // Bits above the window's sign position must all agree for the window to be exact.
    hi_signed   = $signed(acc_reg) >>> (sat_sel + SEL_W'(15));
    hi_unsigned = acc_reg >> (sat_sel + SEL_W'(16));
    no_sat      = (&hi_signed) || (hi_signed == '0) ||
                  (!bus.MAC_TC && (hi_unsigned == '0));
    bus.MAC_OUT = window;
    if (bus.MAC_ACC_SAT && !no_sat) begin
      if (!bus.MAC_TC) begin
        bus.MAC_OUT = 16'hFFFF;
      end else if (acc_reg[ACC_W-1]) begin
        bus.MAC_OUT = 16'h8000;
      end else begin
        bus.MAC_OUT = 16'h7FFF;
      end
    end
  end

endmodule

// File: tb/tb_mac16_accumulator.sv
// Directed-vector bench for mac16_accumulator with hand-computed expectations.
module tb_mac16_accumulator;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   passed = 0;

  mac16_accumulator_if bus();

  mac16_accumulator #(
    .USE_BW      (0),
    .MULTI_WIDTH (16)
  ) dut (
    .MAC_ACC_CLK (clk),
    .acc_ff_rstn (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic en, input logic tc, input logic clr, input logic rnd,
                      input logic [5:0] sel, input logic [15:0] a, input logic [15:0] b);
    bus.EFPGA_MATHB_CLK_EN = en;
    bus.MAC_TC             = tc;
    bus.MAC_ACC_CLEAR      = clr;
    bus.MAC_ACC_RND        = rnd;
    bus.MAC_OUT_SEL        = sel;
    bus.MAC_OPER_DATA      = a;
    bus.MAC_COEF_DATA      = b;
  endtask

  task automatic test_reset();
    load(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 16'h0000);
    bus.MAC_ACC_SAT = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MAC_OUT !== 16'h0000) $display("FAIL reset_assert got=%h exp=%h", bus.MAC_OUT, 16'h0000);
    else begin passed++; $display("ok reset_assert out=%h", bus.MAC_OUT); end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0000) $display("FAIL reset_release got=%h exp=%h", bus.MAC_OUT, 16'h0000);
    else begin passed++; $display("ok reset_release out=%h", bus.MAC_OUT); end
  endtask

  task automatic test_unsigned();
    load(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'd3, 16'd5);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h000F) $display("FAIL unsigned_clear_3x5 got=%h exp=%h", bus.MAC_OUT, 16'h000F);
    else begin passed++; $display("ok unsigned_clear_3x5 out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'd2, 16'd4);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0017) $display("FAIL unsigned_acc_2x4 got=%h exp=%h", bus.MAC_OUT, 16'h0017);
    else begin passed++; $display("ok unsigned_acc_2x4 out=%h", bus.MAC_OUT); end
    load(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd7, 16'd7);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0017) $display("FAIL unsigned_hold got=%h exp=%h", bus.MAC_OUT, 16'h0017);
    else begin passed++; $display("ok unsigned_hold out=%h", bus.MAC_OUT); end
    load(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 16'd7, 16'd7);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0017) $display("FAIL clear_without_en got=%h exp=%h", bus.MAC_OUT, 16'h0017);
    else begin passed++; $display("ok clear_without_en out=%h", bus.MAC_OUT); end
  endtask

  task automatic test_signed();
    load(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 16'hFFFF, 16'h0002);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'hFFFE) $display("FAIL signed_m1x2 got=%h exp=%h", bus.MAC_OUT, 16'hFFFE);
    else begin passed++; $display("ok signed_m1x2 out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 16'hFFFF, 16'hFFFF);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'hFFFF) $display("FAIL signed_acc_m1xm1 got=%h exp=%h", bus.MAC_OUT, 16'hFFFF);
    else begin passed++; $display("ok signed_acc_m1xm1 out=%h", bus.MAC_OUT); end
  endtask

  task automatic test_rounding();
    load(1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 16'h0010, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0001) $display("FAIL round_sel4 got=%h exp=%h", bus.MAC_OUT, 16'h0001);
    else begin passed++; $display("ok round_sel4 out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 16'h0005, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0005) $display("FAIL round_sel0 got=%h exp=%h", bus.MAC_OUT, 16'h0005);
    else begin passed++; $display("ok round_sel0 out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b0, 1'b1, 6'd25, 16'h0002, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0002) $display("FAIL round_sel25 got=%h exp=%h", bus.MAC_OUT, 16'h0002);
    else begin passed++; $display("ok round_sel25 out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 16'h0003, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0001) $display("FAIL clear_beats_rnd got=%h exp=%h", bus.MAC_OUT, 16'h0001);
    else begin passed++; $display("ok clear_beats_rnd out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b0, 1'b1, 6'd16, 16'h8000, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0001) $display("FAIL round_sel16_carry got=%h exp=%h", bus.MAC_OUT, 16'h0001);
    else begin passed++; $display("ok round_sel16_carry out=%h", bus.MAC_OUT); end
  endtask

  task automatic test_saturation();
    bus.MAC_ACC_SAT = 1'b1;
    load(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 16'h7FFF, 16'h7FFF);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h7FFF) $display("FAIL sat_pos got=%h exp=%h", bus.MAC_OUT, 16'h7FFF);
    else begin passed++; $display("ok sat_pos out=%h", bus.MAC_OUT); end
    bus.MAC_ACC_SAT = 1'b0;
    bus.EFPGA_MATHB_CLK_EN = 1'b0;
    #1;
    checks++;
    if (bus.MAC_OUT !== 16'h0001) $display("FAIL nosat_pos_window got=%h exp=%h", bus.MAC_OUT, 16'h0001);
    else begin passed++; $display("ok nosat_pos_window out=%h", bus.MAC_OUT); end
    bus.MAC_ACC_SAT = 1'b1;
    load(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 16'h8000, 16'h7FFF);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h8000) $display("FAIL sat_neg got=%h exp=%h", bus.MAC_OUT, 16'h8000);
    else begin passed++; $display("ok sat_neg out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 16'hFFFF, 16'h0002);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'hFFFE) $display("FAIL sat_small_neg got=%h exp=%h", bus.MAC_OUT, 16'hFFFE);
    else begin passed++; $display("ok sat_small_neg out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'hFFFF, 16'hFFFF);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'hFFFF) $display("FAIL sat_unsigned got=%h exp=%h", bus.MAC_OUT, 16'hFFFF);
    else begin passed++; $display("ok sat_unsigned out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'h8000, 16'h0001);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h8000) $display("FAIL nosat_unsigned_top got=%h exp=%h", bus.MAC_OUT, 16'h8000);
    else begin passed++; $display("ok nosat_unsigned_top out=%h", bus.MAC_OUT); end
    bus.EFPGA_MATHB_CLK_EN = 1'b0;
    bus.MAC_TC = 1'b1;
    #1;
    checks++;
    if (bus.MAC_OUT !== 16'h7FFF) $display("FAIL sat_live_tc got=%h exp=%h", bus.MAC_OUT, 16'h7FFF);
    else begin passed++; $display("ok sat_live_tc out=%h", bus.MAC_OUT); end
    load(1'b1, 1'b1, 1'b1, 1'b0, 6'd24, 16'h7FFF, 16'h7FFF);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h7FFF) $display("FAIL sat_sel24 got=%h exp=%h", bus.MAC_OUT, 16'h7FFF);
    else begin passed++; $display("ok sat_sel24 out=%h", bus.MAC_OUT); end
    load(1'b0, 1'b1, 1'b0, 1'b0, 6'd23, 16'h0000, 16'h0000);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h007F) $display("FAIL nosat_sel23 got=%h exp=%h", bus.MAC_OUT, 16'h007F);
    else begin passed++; $display("ok nosat_sel23 out=%h", bus.MAC_OUT); end
    bus.MAC_ACC_SAT = 1'b0;
  endtask

  task automatic test_window();
    load(1'b1, 1'b0, 1'b1, 1'b0, 6'd8, 16'h1234, 16'h0100);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h1234) $display("FAIL window_sel8 got=%h exp=%h", bus.MAC_OUT, 16'h1234);
    else begin passed++; $display("ok window_sel8 out=%h", bus.MAC_OUT); end
    load(1'b0, 1'b0, 1'b0, 1'b0, 6'd30, 16'h0000, 16'h0000);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h3400) $display("FAIL window_sel30 got=%h exp=%h", bus.MAC_OUT, 16'h3400);
    else begin passed++; $display("ok window_sel30 out=%h", bus.MAC_OUT); end
    load(1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 16'h0000, 16'h0000);
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0001) $display("FAIL window_sel20 got=%h exp=%h", bus.MAC_OUT, 16'h0001);
    else begin passed++; $display("ok window_sel20 out=%h", bus.MAC_OUT); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_vec [4] = '{16'h0001, 16'h0002, 16'h0004, 16'hFFFF};
    logic [15:0] b_vec [4] = '{16'h0001, 16'h0003, 16'h0005, 16'h0001};
    logic [15:0] e_vec [4] = '{16'h0001, 16'h0007, 16'h001B, 16'h001A};
    for (int i = 0; i < 4; i++) begin
      load(1'b1, 1'b0, (i == 0), 1'b0, 6'd0, a_vec[i], b_vec[i]);
      step();
      checks++;
      if (bus.MAC_OUT !== e_vec[i]) $display("FAIL b2b_%0d got=%h exp=%h", i, bus.MAC_OUT, e_vec[i]);
      else begin passed++; $display("ok b2b_%0d out=%h", i, bus.MAC_OUT); end
    end
    bus.EFPGA_MATHB_CLK_EN = 1'b0;
    bus.MAC_ACC_SAT = 1'b1;
    #1;
    checks++;
    if (bus.MAC_OUT !== 16'hFFFF) $display("FAIL b2b_overflow_sat got=%h exp=%h", bus.MAC_OUT, 16'hFFFF);
    else begin passed++; $display("ok b2b_overflow_sat out=%h", bus.MAC_OUT); end
    bus.MAC_ACC_SAT = 1'b0;
  endtask

  task automatic test_async_reset();
    load(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'h00AB, 16'h0001);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MAC_OUT !== 16'h0000) $display("FAIL async_reset_mid got=%h exp=%h", bus.MAC_OUT, 16'h0000);
    else begin passed++; $display("ok async_reset_mid out=%h", bus.MAC_OUT); end
    rst_n = 1'b1;
    bus.EFPGA_MATHB_CLK_EN = 1'b0;
    step();
    checks++;
    if (bus.MAC_OUT !== 16'h0000) $display("FAIL async_reset_after got=%h exp=%h", bus.MAC_OUT, 16'h0000);
    else begin passed++; $display("ok async_reset_after out=%h", bus.MAC_OUT); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_rounding();
    test_saturation();
    test_window();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
